// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - Shared encodings and widths for the instruction-fetch stage
package if_stage_pkg;

    localparam int INSTR_WIDTH = 32;
    localparam int ADDR_WIDTH  = 32;

    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0;

    localparam logic [1:0] PCSRC_SEQ    = 2'b00;
    localparam logic [1:0] PCSRC_JUMP   = 2'b01;
    localparam logic [1:0] PCSRC_BRANCH = 2'b10;
    localparam logic [1:0] PCSRC_JR     = 2'b11;

    typedef enum logic {
        IF_RUN  = 1'b0,
        IF_HOLD = 1'b1
    } ifState_e;

endpackage

// File: rtl/if_skid_buffer.sv
// rtl/if_skid_buffer.sv - One-entry buffer holding a fetched word and its PC+4 while ID stalls
module if_skid_buffer
    import if_stage_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   load,
    input  logic                   drain,
    input  logic [INSTR_WIDTH-1:0] wrInstr,
    input  logic [ADDR_WIDTH-1:0]  wrPcPlus4,
    output logic                   valid,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0]  pcPlus4
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid   <= 1'b0;
            instr   <= NOP_INSTR;
            pcPlus4 <= '0;
        end else if (load) begin
            valid   <= 1'b1;
            instr   <= wrInstr;
            pcPlus4 <= wrPcPlus4;
        end else if (drain) begin
            valid   <= 1'b0;
        end
    end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction-fetch stage: PC, imem handshake, delay-slot redirect, IF/ID register
module if_stage
    import if_stage_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'hBFC0_0000
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [1:0]             PCSrcSel,
    input  logic [ADDR_WIDTH-1:0]  Jump_Target,
    input  logic [ADDR_WIDTH-1:0]  Branch_Target,
    input  logic [ADDR_WIDTH-1:0]  JR_Target,
    input  logic                   ID_Stall,
    input  logic                   IF_Flush,
    input  logic                   IMem_Ready,
    input  logic [INSTR_WIDTH-1:0] IMem_Data,
    output logic                   IMem_Req,
    output logic [ADDR_WIDTH-1:0]  IMem_Addr,
    output logic [INSTR_WIDTH-1:0] IFID_Instr,
    output logic [ADDR_WIDTH-1:0]  IFID_PCPlus4,
    output logic                   IFID_Valid
);

    ifState_e               state, nextState;
    logic [ADDR_WIDTH-1:0]  pc, pcPlus4, nextPc, redirTarget, pendTarget;
    logic                   pendValid;
    logic                   fetchDone, idAccept, redir, skidLoad, skidDrain, skidValid;
    logic [INSTR_WIDTH-1:0] skidInstr;
    logic [ADDR_WIDTH-1:0]  skidPcPlus4;

    assign pcPlus4   = pc + ADDR_WIDTH'(4);
    assign IMem_Req  = reset_n & (state == IF_RUN);
    assign IMem_Addr = {pc[ADDR_WIDTH-1:2], 2'b00};
    assign fetchDone = IMem_Req & IMem_Ready;
    assign idAccept  = ~ID_Stall | ~IFID_Valid;
    assign redir     = IFID_Valid & ~ID_Stall & (PCSrcSel != PCSRC_SEQ);
    assign skidLoad  = fetchDone & ~idAccept;
    assign skidDrain = skidValid & ~ID_Stall;

    always_comb begin
        redirTarget = pcPlus4;
        case (PCSrcSel)
            PCSRC_JUMP:   redirTarget = Jump_Target;
            PCSRC_BRANCH: redirTarget = Branch_Target;
            PCSRC_JR:     redirTarget = JR_Target;
            default:      redirTarget = pcPlus4;
        endcase
        redirTarget[1:0] = 2'b00;
    end

    // In HOLD the delay slot already sits in the skid buffer, so a redirect retargets the PC directly.
    always_comb begin
        nextPc = pc;
        if (fetchDone) begin
            if (redir)          nextPc = redirTarget;
            else if (pendValid) nextPc = pendTarget;
            else                nextPc = pcPlus4;
        end else if (redir && state == IF_HOLD) begin
            nextPc = redirTarget;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IF_RUN:  if (skidLoad)  nextState = IF_HOLD;
            IF_HOLD: if (!ID_Stall) nextState = IF_RUN;
            default: nextState = IF_RUN;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IF_RUN;
            pc         <= RESET_PC;
            pendValid  <= 1'b0;
            pendTarget <= '0;
        end else begin
            state <= nextState;
            pc    <= nextPc;
            if (fetchDone) begin
                pendValid <= 1'b0;
            end else if (redir && state == IF_RUN) begin
                pendValid  <= 1'b1;
                pendTarget <= redirTarget;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            IFID_Instr   <= NOP_INSTR;
            IFID_PCPlus4 <= '0;
            IFID_Valid   <= 1'b0;
        end else if (skidDrain) begin
            IFID_Instr   <= skidInstr;
            IFID_PCPlus4 <= skidPcPlus4;
            IFID_Valid   <= ~IF_Flush;
        end else if (idAccept) begin
            if (fetchDone) begin
                IFID_Instr   <= IMem_Data;
                IFID_PCPlus4 <= pcPlus4;
                IFID_Valid   <= ~IF_Flush;
            end else begin
                IFID_Valid   <= 1'b0;
            end
        end
    end

    if_skid_buffer #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) skid (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (skidLoad),
        .drain    (skidDrain),
        .wrInstr  (IMem_Data),
        .wrPcPlus4(pcPlus4),
        .valid    (skidValid),
        .instr    (skidInstr),
        .pcPlus4  (skidPcPlus4)
    );

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - Directed scoreboard bench for if_stage
module tb_if_stage;

    logic        clock;
    logic        reset_n;
    logic [1:0]  PCSrcSel;
    logic [31:0] Jump_Target, Branch_Target, JR_Target;
    logic        ID_Stall, IF_Flush, IMem_Ready;
    logic [31:0] IMem_Data;
    logic        IMem_Req;
    logic [31:0] IMem_Addr, IFID_Instr, IFID_PCPlus4;
    logic        IFID_Valid;

    logic [31:0] expQ[$];
    int          checks = 0;
    int          errors = 0;

    if_stage #(
        .ADDR_WIDTH(32),
        .RESET_PC  (32'hBFC0_0000)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .PCSrcSel     (PCSrcSel),
        .Jump_Target  (Jump_Target),
        .Branch_Target(Branch_Target),
        .JR_Target    (JR_Target),
        .ID_Stall     (ID_Stall),
        .IF_Flush     (IF_Flush),
        .IMem_Ready   (IMem_Ready),
        .IMem_Data    (IMem_Data),
        .IMem_Req     (IMem_Req),
        .IMem_Addr    (IMem_Addr),
        .IFID_Instr   (IFID_Instr),
        .IFID_PCPlus4 (IFID_PCPlus4),
        .IFID_Valid   (IFID_Valid)
    );

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'h5A5A_0001;
    endfunction

    assign IMem_Data = memWord(IMem_Addr);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkBit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [31:0] a);
        expQ.push_back(a);
    endtask

    task automatic pop(input string tag);
        logic [31:0] a;
        chkBit({tag, ".pending"}, expQ.size() != 0, 1'b1);
        if (expQ.size() == 0) return;
        a = expQ.pop_front();
        chkBit({tag, ".valid"}, IFID_Valid, 1'b1);
        chk({tag, ".instr"}, IFID_Instr, memWord(a));
        chk({tag, ".pc4"}, IFID_PCPlus4, a + 32'd4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        reset_n = 1'b0; PCSrcSel = 2'b00; Jump_Target = '0; Branch_Target = '0; JR_Target = '0;
        ID_Stall = 1'b0; IF_Flush = 1'b0; IMem_Ready = 1'b1;
        tick; tick;
        chkBit("rst.req", IMem_Req, 1'b0);
        chkBit("rst.valid", IFID_Valid, 1'b0);
        chk("rst.instr", IFID_Instr, 32'h0);
        chk("rst.pc4", IFID_PCPlus4, 32'h0);

        reset_n = 1'b1; #1;
        chkBit("boot.req", IMem_Req, 1'b1);
        chk("boot.addr", IMem_Addr, 32'hBFC0_0000);

        for (int k = 0; k < 5; k++) begin
            a = 32'hBFC0_0000 + 32'(k) * 32'd4;
            chk("seq.addr", IMem_Addr, a);
            push(a); tick; pop("seq");
        end

        // taken branch in ID, delay slot fetched with zero wait
        PCSrcSel = 2'b10; Branch_Target = 32'hBFC0_0102;
        chk("br.slotaddr", IMem_Addr, 32'hBFC0_0014);
        push(32'hBFC0_0014); tick; PCSrcSel = 2'b00;
        pop("br.slot");
        chk("br.target", IMem_Addr, 32'hBFC0_0100);
        push(32'hBFC0_0100); tick; pop("br.first");

        // taken branch with the delay-slot fetch waiting 3 cycles
        push(32'hBFC0_0104); tick; pop("wb.beq");
        PCSrcSel = 2'b10; Branch_Target = 32'hBFC0_0200; IMem_Ready = 1'b0;
        tick; PCSrcSel = 2'b00;
        chkBit("wb.bubble", IFID_Valid, 1'b0);
        chk("wb.hold1", IMem_Addr, 32'hBFC0_0108);
        tick;
        chkBit("wb.req", IMem_Req, 1'b1);
        chk("wb.hold2", IMem_Addr, 32'hBFC0_0108);
        tick;
        chk("wb.hold3", IMem_Addr, 32'hBFC0_0108);
        IMem_Ready = 1'b1;
        push(32'hBFC0_0108); tick; pop("wb.slot");
        chk("wb.target", IMem_Addr, 32'hBFC0_0200);
        push(32'hBFC0_0200); tick; pop("wb.first");

        // ID stall for two cycles while a fetch completes
        ID_Stall = 1'b1; tick;
        chkBit("st.req", IMem_Req, 1'b0);
        chkBit("st.valid", IFID_Valid, 1'b1);
        chk("st.pc4", IFID_PCPlus4, 32'hBFC0_0204);
        chk("st.instr", IFID_Instr, memWord(32'hBFC0_0200));
        tick;
        chkBit("st.req2", IMem_Req, 1'b0);
        chk("st.pc4b", IFID_PCPlus4, 32'hBFC0_0204);
        ID_Stall = 1'b0;
        push(32'hBFC0_0204); tick; pop("st.drain");
        chkBit("st.reqback", IMem_Req, 1'b1);
        chk("st.addr", IMem_Addr, 32'hBFC0_0208);
        push(32'hBFC0_0208); tick; pop("st.next");

        // flush squashes the loading word, PC still advances
        IF_Flush = 1'b1; tick; IF_Flush = 1'b0;
        chkBit("fl.valid", IFID_Valid, 1'b0);
        chk("fl.addr", IMem_Addr, 32'hBFC0_0210);
        push(32'hBFC0_0210); tick; pop("fl.next");

        // flush together with stall: stall wins
        ID_Stall = 1'b1; IF_Flush = 1'b1; tick; ID_Stall = 1'b0; IF_Flush = 1'b0;
        chkBit("fs.valid", IFID_Valid, 1'b1);
        chk("fs.pc4", IFID_PCPlus4, 32'hBFC0_0214);
        chkBit("fs.req", IMem_Req, 1'b0);
        push(32'hBFC0_0214); tick; pop("fs.drain");

        // jr to the top of memory, then PC wraps to zero
        PCSrcSel = 2'b11; JR_Target = 32'hFFFF_FFFF;
        push(32'hBFC0_0218); tick; PCSrcSel = 2'b00;
        pop("jr.slot");
        chk("jr.target", IMem_Addr, 32'hFFFF_FFFC);
        push(32'hFFFF_FFFC); tick; pop("wrap.fetch");
        chk("wrap.addr", IMem_Addr, 32'h0000_0000);

        PCSrcSel = 2'b01; Jump_Target = 32'h0000_1000;
        push(32'h0000_0000); tick; PCSrcSel = 2'b00;
        pop("j.slot");
        chk("j.target", IMem_Addr, 32'h0000_1000);

        // reset asserted while a request is waiting
        IMem_Ready = 1'b0; tick;
        chkBit("rw.reqwait", IMem_Req, 1'b1);
        #2 reset_n = 1'b0; #1;
        chkBit("rw.req", IMem_Req, 1'b0);
        chkBit("rw.valid", IFID_Valid, 1'b0);
        chk("rw.instr", IFID_Instr, 32'h0);
        chk("rw.pc4", IFID_PCPlus4, 32'h0);
        tick;
        reset_n = 1'b1; IMem_Ready = 1'b1; #1;
        chkBit("rw.reqback", IMem_Req, 1'b1);
        chk("rw.addr", IMem_Addr, 32'hBFC0_0000);
        push(32'hBFC0_0000); tick; pop("rw.first");

        chk("sb.empty", 32'(expQ.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline; owns the PC and the instruction-memory request handshake.
- Feeds the IF/ID pipeline register that drives the ID-stage control decoder.
- Consumes that decoder's PCSrcSel, IF_Flush and ID_Stall outputs.
- Implements MIPS32 branch-delay-slot semantics: a redirect from ID applies to the PC after the delay-slot fetch.

Parameters:
- RESET_PC, 32'hBFC0_0000, PC loaded on reset.
- ADDR_WIDTH, 32, PC and target width.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- PCSrcSel  in  2  from ID control: 00 PC+4; 01 jump (J/Jal); 10 taken branch; 11 jump register.
- Jump_Target  in  32  {PC+4[31:28], instr_index, 2'b00}, computed in ID.
- Branch_Target  in  32  PC+4 + (signext imm << 2), computed in ID.
- JR_Target  in  32  forwarded rs value.
- ID_Stall  in  1  ID cannot accept a new instruction this cycle.
- IF_Flush  in  1  squash the instruction entering IF/ID.
- IMem_Ready  in  1  instruction memory returns data this cycle.
- IMem_Data  in  32  instruction word, valid when IMem_Ready=1.
- IMem_Req  out  1  fetch request.
- IMem_Addr  out  32  word address, bits [1:0] always 00.
- IFID_Instr  out  32  instruction to ID.
- IFID_PCPlus4  out  32  fetch PC + 4.
- IFID_Valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (async, reset_n=0):
  - PC=RESET_PC; state=RUN; pend_valid=0.
  - IMem_Req=0; IFID_Instr=0 (NOP); IFID_PCPlus4=0; IFID_Valid=0.
  - Any outstanding request is abandoned; memory must tolerate a dropped request.
- First cycle after release: IMem_Req=1, IMem_Addr=RESET_PC.
- Handshake:
  - In RUN, IMem_Req=1 and IMem_Addr=PC{[31:2],2'b00}, held stable until IMem_Ready=1.
  - Fetch completes on a cycle with Req&Ready.
  - Zero-wait memory (Ready same cycle as Req) gives one instruction per clock.
- Redirect:
  - redir = IFID_Valid & ~ID_Stall & (PCSrcSel!=00).
  - Target mux per the PCSrcSel encoding above.
  - Low two target bits are ignored.
- Next PC on fetch completion: this cycle's redir target; else pend_target if pend_valid (clearing pend_valid); else PC+4. PC+4 wraps modulo 2^32.
- redir with no fetch completing this cycle: the delay slot is still in flight, so capture pend_target and set pend_valid.
- A redir arriving while pend_valid=1 is impossible by ISA (branch in delay slot is undefined). Behaviour is last-writer-wins.
- IF/ID load:
  - Load when the fetch completes and ID accepts (~ID_Stall | ~IFID_Valid).
  - IFID_Instr <= IMem_Data, IFID_PCPlus4 <= PC+4, IFID_Valid <= ~IF_Flush.
- Bubble: if ID accepts and no instruction is available (no completion, nothing buffered), IFID_Valid <= 0 next edge.
- Stall:
  - If a fetch completes while ID_Stall=1 and IFID_Valid=1, the word and its PC+4 go into a one-entry skid buffer; state -> HOLD.
  - PC still advances; IMem_Req=0 in HOLD.
  - HOLD -> RUN on the first cycle with ID_Stall=0: the buffer loads IF/ID that edge and IMem_Req reasserts the following cycle.
- IF_Flush:
  - Applies to whatever loads IF/ID that edge, whether from memory or from the skid buffer.
  - The flushed word is discarded (IFID_Valid=0); PC advance is unaffected.
  - With IF_Flush and ID_Stall both set, the stall wins: IF/ID is held unchanged.
- Latency: address-to-IF/ID is 1 cycle with zero-wait memory, N+1 cycles with N wait states.

Decomposition:
- Shared package / `cpu_para.v` gains:
  - PCSRC_* encodings (PCSRC_SEQ=2'b00, PCSRC_JUMP=2'b01, PCSRC_BRANCH=2'b10, PCSRC_JR=2'b11);
  - INSTR_WIDTH, ADDR_WIDTH;
  - NOP_INSTR=32'h0;
  - IF state encodings.
- One sub-module: if_skid_buffer (one-entry buffer holding instr and PC+4, with valid).
- The PC register and next-PC mux stay inline.

Test Plan:
- Reset then free-run, zero-wait memory -> IMem_Addr BFC00000, BFC00004, BFC00008 on consecutive cycles; IFID_PCPlus4 trails by one cycle; IFID_Valid=1 from cycle 2.
- beq at BFC00010 taken, Branch_Target=BFC00100 -> delay slot BFC00014 still enters IF/ID, next fetch BFC00100.
- Same branch with IMem_Ready delayed 3 cycles on the delay-slot fetch -> pend_valid set; after completion IMem_Addr=BFC00100; no extra instruction issued.
- ID_Stall held 2 cycles while fetch completes -> HOLD; IMem_Req=0; IF/ID unchanged; on release the buffered word enters IF/ID exactly once and no instruction is lost or duplicated.
- IF_Flush pulse with ID_Stall=0 -> IFID_Valid=0 next cycle and PC advances normally; PC=FFFFFFFC -> next IMem_Addr=00000000.
- reset_n asserted mid-wait (Req high, Ready low) -> outputs clear immediately; after release fetch restarts at RESET_PC.
